cpu_lcd_pio: RTL and testbench

CPU_LCD_PIO -- requirements
Module: cpu_lcd_pio

---
 rtl/cpu_lcd_pkg.sv | 43 ++++
 rtl/cpu_lcd_phase_cnt.sv | 28 ++
 rtl/cpu_lcd_pio.sv | 175 +++++++++++++++++
 tb/tb_cpu_lcd_pio.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_lcd_pkg.sv
// Shared types and constants for the CPU-driven LCD parallel I/O port.
package cpu_lcd_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ADDR_W = 2;

  // Avalon-MM word addresses
  localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_CMD    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_TIMING = 2'd3;

  // CTRL register bit positions
  localparam int unsigned CTRL_RS_BIT     = 0;
  localparam int unsigned CTRL_RW_BIT     = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;

  // CMD write bits and STATUS read bits
  localparam int unsigned CMD_START_BIT    = 0;
  localparam int unsigned CMD_CLR_DONE_BIT = 1;
  localparam int unsigned STAT_BUSY_BIT    = 0;
  localparam int unsigned STAT_DONE_BIT    = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_HOLD  = 2'd3
  } lcd_state_e;

  // TIMING register payload, laid out as it appears on writedata[23:0]
  typedef struct packed {
    logic [CNT_W-1:0] hold;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] setup;
  } lcd_timing_t;

  // Counter reload for a phase of max(len,1) clocks
  function automatic logic [CNT_W-1:0] phase_reload(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

endpackage

// File: rtl/cpu_lcd_phase_cnt.sv
// 8-bit loadable down-counter with terminal count, shared by all strobe phases.
module cpu_lcd_phase_cnt
  import cpu_lcd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority; decrement saturates at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/cpu_lcd_pio.sv
// Avalon-MM slave that drives a character LCD bus with a programmable
// setup / enable-high / hold strobe.
module cpu_lcd_pio
  import cpu_lcd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEF_SETUP  = 2,
  parameter int unsigned DEF_HIGH   = 12,
  parameter int unsigned DEF_HOLD   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] lcd_data,
  output logic                  lcd_rs,
  output logic                  lcd_rw,
  output logic                  lcd_en,
  output logic                  irq
);

  localparam lcd_timing_t TIMING_RST = '{
    hold:  CNT_W'(DEF_HOLD),
    high:  CNT_W'(DEF_HIGH),
    setup: CNT_W'(DEF_SETUP)
  };

  lcd_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rs_q, rw_q, irq_en_q, done_q, lcd_en_q;
  lcd_timing_t           timing_q;

  logic                  wr_en, busy, start, clr_done, done_set;
  logic                  cnt_load, cnt_en, cnt_tc;
  logic [CNT_W-1:0]      cnt_val;
  logic                  unused_wd;

  assign wr_en    = chipselect & ~write_n;
  assign busy     = (state_q != ST_IDLE);
  assign start    = wr_en && (address == ADDR_CMD) && writedata[CMD_START_BIT] && !busy;
  assign clr_done = wr_en && (address == ADDR_CMD) && writedata[CMD_CLR_DONE_BIT];
  assign done_set = (state_q == ST_HOLD) && cnt_tc;
  assign unused_wd = ^writedata[31:24];

  cpu_lcd_phase_cnt u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .tc_c     (cnt_tc)
  );

  // Next-state and phase-counter control; each phase ends on terminal count
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETUP;
          cnt_load = 1'b1;
          cnt_val  = phase_reload(timing_q.setup);
        end
      end
      ST_SETUP: begin
        if (cnt_tc) begin
          state_d  = ST_HIGH;
          cnt_load = 1'b1;
          cnt_val  = phase_reload(timing_q.high);
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HIGH: begin
        if (cnt_tc) begin
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = phase_reload(timing_q.hold);
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_tc) begin
          state_d = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; enable strobe registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lcd_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lcd_en_q <= (state_d == ST_HIGH);
    end
  end

  // Bus-visible registers; bus-shaping fields frozen while a strobe runs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      rs_q     <= 1'b0;
      rw_q     <= 1'b0;
      irq_en_q <= 1'b0;
      timing_q <= TIMING_RST;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA: begin
          if (!busy) data_q <= writedata[DATA_WIDTH-1:0];
        end
        ADDR_CTRL: begin
          irq_en_q <= writedata[CTRL_IRQ_EN_BIT];
          if (!busy) begin
            rs_q <= writedata[CTRL_RS_BIT];
            rw_q <= writedata[CTRL_RW_BIT];
          end
        end
        ADDR_TIMING: begin
          if (!busy) timing_q <= lcd_timing_t'(writedata[23:0]);
        end
        default: ;
      endcase
    end
  end

  // Done flag: completion beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else if (done_set) begin
      done_q <= 1'b1;
    end else if (clr_done) begin
      done_q <= 1'b0;
    end
  end

  // Read mux with zero-fill
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[DATA_WIDTH-1:0] = data_q;
      ADDR_CTRL: begin
        readdata[CTRL_RS_BIT]     = rs_q;
        readdata[CTRL_RW_BIT]     = rw_q;
        readdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      ADDR_CMD: begin
        readdata[STAT_BUSY_BIT] = busy;
        readdata[STAT_DONE_BIT] = done_q;
      end
      ADDR_TIMING: readdata[23:0] = timing_q;
      default:     readdata = '0;
    endcase
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = rw_q;
  assign lcd_en   = lcd_en_q;
  assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_cpu_lcd_pio.sv
// Directed self-checking bench for cpu_lcd_pio with default parameters.
module tb_cpu_lcd_pio;

  logic        clk, reset, chipselect, write_n;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, irq;

  int checks = 0;
  int errors = 0;

  cpu_lcd_pio dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .lcd_data   (lcd_data),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .irq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expd);
    end
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] expd, input string tag);
    address = a;
    #1;
    chk(tag, readdata, expd);
  endtask

  // One bus write; returns 1ns after the capturing edge
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Count clocks until busy drops, bounded
  task automatic wait_idle(input int max_cyc, output int n);
    n = 0;
    address = 2'd2;
    #1;
    while (readdata[0] === 1'b1 && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Observe one strobe from the start edge onward, one sample per clock
  task automatic measure(input logic [7:0] exp_data, output int busy_n,
                         output int en_n, output int en_first, output bit stable);
    busy_n = 0; en_n = 0; en_first = -1; stable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      address = 2'd2;
      #1;
      if (readdata[0] === 1'b1) busy_n++;
      if (lcd_en === 1'b1) begin
        if (en_n == 0) en_first = i;
        en_n++;
      end
      if (lcd_data !== exp_data) stable = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  int n, busy_n, en_n, en_first;
  bit stable;

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    rd_chk(2'd0, 32'h0, "rst_data");
    rd_chk(2'd1, 32'h0, "rst_ctrl");
    rd_chk(2'd2, 32'h0, "rst_status");
    rd_chk(2'd3, 32'h00020C02, "rst_timing");
    chk("rst_lcd_en", 32'(lcd_en), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    // Default timing strobe: 2 setup, 12 high, 2 hold
    wr(2'd0, 32'hA5);
    rd_chk(2'd0, 32'hA5, "data_rd");
    wr(2'd2, 32'h1);
    measure(8'hA5, busy_n, en_n, en_first, stable);
    chk("def_busy_len", 32'(busy_n), 32'd16);
    chk("def_en_len", 32'(en_n), 32'd12);
    chk("def_en_first", 32'(en_first), 32'd2);
    chk("def_data_stable", 32'(stable), 32'd1);
    rd_chk(2'd2, 32'h2, "def_done");

    // Busy protection: writes and a second start during the strobe
    wr(2'd2, 32'h2);
    rd_chk(2'd2, 32'h0, "clr_done");
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h3C);
    wr(2'd3, 32'h00010101);
    wr(2'd2, 32'h1);
    chk("busy_lcd_data", 32'(lcd_data), 32'hA5);
    rd_chk(2'd0, 32'hA5, "busy_data_rd");
    rd_chk(2'd3, 32'h00020C02, "busy_timing_rd");
    wait_idle(40, n);
    chk("busy_remaining", 32'(n), 32'd13);
    rd_chk(2'd2, 32'h2, "busy_done");
    wr(2'd2, 32'h2);
    repeat (20) @(posedge clk);
    #1;
    rd_chk(2'd2, 32'h0, "busy_single_done");

    // Interrupt
    wr(2'd1, 32'h4);
    rd_chk(2'd1, 32'h4, "ctrl_rd");
    chk("irq_low", 32'(irq), 32'h0);
    wr(2'd2, 32'h1);
    wait_idle(40, n);
    chk("irq_strobe_len", 32'(n), 32'd16);
    chk("irq_high", 32'(irq), 32'h1);
    wr(2'd2, 32'h2);
    chk("irq_cleared", 32'(irq), 32'h0);
    rd_chk(2'd2, 32'h0, "irq_status_clr");
    wr(2'd2, 32'h1);
    wait_idle(40, n);
    rd_chk(2'd2, 32'h2, "irq_done_again");
    wr(2'd2, 32'h3);
    rd_chk(2'd2, 32'h1, "clr_and_start");
    chk("clr_and_start_irq", 32'(irq), 32'h0);
    wait_idle(40, n);
    chk("restart_len", 32'(n), 32'd16);
    chk("restart_irq", 32'(irq), 32'h1);

    // Zero timing: every phase one clock
    wr(2'd3, 32'h0);
    rd_chk(2'd3, 32'h0, "zero_timing_rd");
    wr(2'd2, 32'h3);
    measure(8'hA5, busy_n, en_n, en_first, stable);
    chk("zero_busy_len", 32'(busy_n), 32'd3);
    chk("zero_en_len", 32'(en_n), 32'd1);
    chk("zero_en_first", 32'(en_first), 32'd1);

    // Reset in the middle of the high phase
    wr(2'd3, 32'h00030503);
    wr(2'd1, 32'h7);
    wr(2'd0, 32'h5A);
    wr(2'd2, 32'h3);
    n = 0;
    while (lcd_en !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mid_en_reached", 32'(lcd_en), 32'h1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_en", 32'(lcd_en), 32'h0);
    chk("rst_async_data", 32'(lcd_data), 32'h0);
    chk("rst_async_rs", 32'(lcd_rs), 32'h0);
    chk("rst_async_rw", 32'(lcd_rw), 32'h0);
    chk("rst_async_irq", 32'(irq), 32'h0);
    rd_chk(2'd2, 32'h0, "rst_mid_status");
    rd_chk(2'd1, 32'h0, "rst_mid_ctrl");
    rd_chk(2'd3, 32'h00020C02, "rst_mid_timing");
    rd_chk(2'd0, 32'h0, "rst_mid_data");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd_chk(2'd2, 32'h0, "post_rst_idle");
    chk("post_rst_en", 32'(lcd_en), 32'h0);

    // First start after reset runs a full default strobe
    wr(2'd2, 32'h1);
    measure(8'h00, busy_n, en_n, en_first, stable);
    chk("post_busy_len", 32'(busy_n), 32'd16);
    chk("post_en_len", 32'(en_n), 32'd12);
    chk("post_en_first", 32'(en_first), 32'd2);
    rd_chk(2'd2, 32'h2, "post_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
